wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Writeback arbiter and the write-side driver of the physical register file.
//   Collects results from NUM_FU functional units, each into its own small FIFO.
//   Picks up to two results per cycle, round-robin, and drives the PRF's two
//   write ports (wen/wtag/wdata 0/1) from registers.
//   The same registered write ports double as the wakeup broadcast to the issue queues.
// PARAMETERS
//   XLEN        core_pkg::XLEN   datapath width
//   PREGS       core_pkg::PREGS  physical registers; tags are core_pkg::preg_tag_t
//   NUM_FU      4                functional-unit result sources (2..8)
//   FIFO_DEPTH  2                entries per FU FIFO (power of 2, >=2)
// PORTS
//   clk       in   1                   clock, rising edge
//   reset     in   1                   asynchronous, active-low reset
//   flush     in   1                   synchronous squash of all buffered results
//   fu_valid  in   [NUM_FU]            result valid per FU
//   fu_tag    in   [NUM_FU] preg_tag_t destination physical tag per FU
//   fu_data   in   [NUM_FU][XLEN]      result data per FU
//   fu_ready  out  [NUM_FU]            FU FIFO can accept (not full)
//   wen0      out  1                   PRF write port 0 enable (registered)
//   wtag0     out  preg_tag_t          PRF write port 0 tag
//   wdata0    out  XLEN                PRF write port 0 data
//   wen1      out  1                   PRF write port 1 enable (registered)
//   wtag1     out  preg_tag_t          PRF write port 1 tag
//   wdata1    out  XLEN                PRF write port 1 data
// BEHAVIOUR
//   - Reset (reset=0, async): FIFOs empty, rr_ptr=0, wen0/wen1=0, wtag*/wdata*=0.
//     fu_ready=all 1, decoded from count.
//   - Enqueue: fu_valid[i] && fu_ready[i] at a rising edge pushes {tag,data} into FIFO i.
//     fu_valid without fu_ready is ignored. The FU must hold the result until it is accepted.
//   - fu_ready[i] = (count[i] != FIFO_DEPTH), decoded from registered count only.
//     A full FIFO that pops this cycle still shows ready=0 (no pass-through).
//   - Grant (combinational each cycle): scan FIFOs i = rr_ptr, rr_ptr+1, ... mod NUM_FU.
//     First non-empty FIFO goes to port 0; second non-empty FIFO goes to port 1.
//     Both granted heads are popped at the edge.
//   - Output regs at the edge: wen0 <= port0 granted, {wtag0,wdata0} <= head, else wen0 <= 0.
//     Same for port 1. Tag/data hold their previous value when wen=0.
//   - Port 0 is filled before port 1: wen1=1 implies wen0=1.
//   - rr_ptr <= (last granted index + 1) mod NUM_FU. Unchanged when nothing is granted.
//   - Latency: valid accepted at edge E0 -> grant in the following cycle -> wen high
//     after edge E1, i.e. 2 edges from acceptance to PRF write. The PRF bypass covers
//     same-cycle readers.
//   - Per-FU order is strict FIFO. No ordering between different FUs.
//   - Simultaneous push and pop on the same FIFO is allowed; count unchanged.
//     Pointers wrap mod FIFO_DEPTH.
//   - flush=1 at an edge: all FIFO counts <- 0, wen0/wen1 <- 0, rr_ptr kept.
//     Pushes in the same cycle are dropped. flush overrides grant and enqueue.
//   - Reset mid-operation discards all buffered results. No partial writes are emitted.
//   - Rename guarantees distinct tags in flight, so the two ports never carry the same tag.
//     A bench assertion checks wen0 && wen1 -> wtag0 != wtag1.
// CONFIGURATION
//   WB_ARB_STATS_EN defined: adds outputs wb_count[31:0] and stall_cycles[31:0].
//     Both are saturating and reset to 0; flush does not clear them.
//     wb_count adds the number of grants per cycle (0..2).
//     stall_cycles increments when any FIFO is non-empty and not granted that cycle.
//   WB_ARB_STATS_EN undefined: those ports and counters do not exist. Behaviour is otherwise identical.
// TESTING
//   1 reset=0 mid-traffic -> wen0=wen1=0 immediately; fu_ready=4'b1111 after release.
//   2 FU2 pushes tag 5, data 32'hDEAD_BEEF once -> 2 edges later wen0=1, wtag0=5,
//     wdata0=DEADBEEF, wen1=0; next cycle wen0=0.
//   3 FU0..3 push tags 1..4 in one cycle, rr_ptr=0 -> (wtag0,wtag1)=(1,2), then (3,4), then wen=0.
//   4 FU0,FU1,FU2 valid every cycle -> port pairs rotate (0,1),(2,0),(1,2),(0,1).
//   5 All 4 FUs push every cycle, tags incrementing -> fu_ready drops within 2 cycles.
//     Every tag is written exactly once, in push order per FU, with no loss or duplication.
//   6 FIFOs full, flush=1 one cycle -> next cycle wen0=wen1=0, fu_ready=4'b1111.
//     With STATS_EN, wb_count is unchanged by the flush.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers functional-unit results in per-FU FIFOs and drives
// the two registered PRF write ports (also the issue-queue wakeup broadcast),
// picking up to two results per cycle in round-robin order.
// Optional feature macro: WB_ARB_STATS_EN adds wb_count/stall_cycles outputs.

package core_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned PREGS = 64;
  localparam int unsigned TAG_W = $clog2(PREGS);
  typedef logic [TAG_W-1:0] preg_tag_t;
endpackage

module wb_arbiter #(
  parameter int unsigned XLEN       = core_pkg::XLEN,
  parameter int unsigned PREGS      = core_pkg::PREGS,
  parameter int unsigned NUM_FU     = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    flush,
  input  logic [NUM_FU-1:0]                       fu_valid,
  input  logic [NUM_FU-1:0][$clog2(PREGS)-1:0]    fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]             fu_data,
  output logic [NUM_FU-1:0]                       fu_ready,
  output logic                                    wen0,
  output logic [$clog2(PREGS)-1:0]                wtag0,
  output logic [XLEN-1:0]                         wdata0,
  output logic                                    wen1,
  output logic [$clog2(PREGS)-1:0]                wtag1,
  output logic [XLEN-1:0]                         wdata1
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]                             wb_count,
  output logic [31:0]                             stall_cycles
`endif
);

  localparam int unsigned TAG_W = $clog2(PREGS);
  localparam int unsigned IDX_W = $clog2(NUM_FU);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } entry_t;

  entry_t           mem_q    [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [NUM_FU];
  logic [PTR_W-1:0] rd_ptr_d [NUM_FU];
  logic [PTR_W-1:0] wr_ptr_q [NUM_FU];
  logic [PTR_W-1:0] wr_ptr_d [NUM_FU];
  logic [CNT_W-1:0] count_q  [NUM_FU];
  logic [CNT_W-1:0] count_d  [NUM_FU];
  entry_t           head     [NUM_FU];

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             wen0_q, wen0_d, wen1_q, wen1_d;
  entry_t           out0_q, out0_d, out1_q, out1_d;

  logic [NUM_FU-1:0] push, pop, nonempty;
  logic              g0_vld, g1_vld;
  logic [IDX_W-1:0]  g0_idx, g1_idx;
  logic [IDX_W:0]    scan;

  // Round-robin successor of an FU index
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_FU - 1)) return '0;
    return idx + IDX_W'(1);
  endfunction

  // FIFO status decoded from registered counts only (no pass-through when full)
  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = (count_q[i] != CNT_W'(FIFO_DEPTH));
      nonempty[i] = (count_q[i] != '0);
      head[i]     = mem_q[i][rd_ptr_q[i]];
      push[i]     = fu_valid[i] && fu_ready[i];
    end
  end

  // Scan from rr_ptr: first non-empty FIFO to port 0, second to port 1
  always_comb begin
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0_idx = '0;
    g1_idx = '0;
    scan   = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      scan = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (scan >= (IDX_W+1)'(NUM_FU)) scan = scan - (IDX_W+1)'(NUM_FU);
      if (nonempty[scan[IDX_W-1:0]]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = scan[IDX_W-1:0];
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = scan[IDX_W-1:0];
        end
      end
    end
  end

  // Pop vector from the two grants
  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      pop[i] = (g0_vld && (g0_idx == IDX_W'(i))) || (g1_vld && (g1_idx == IDX_W'(i)));
    end
  end

  // FIFO pointer/count next state; flush squashes everything buffered
  always_comb begin
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        count_d[i]  = '0;
      end else begin
        if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
        if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
          2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
          default: count_d[i] = count_q[i];
        endcase
      end
    end
  end

  // Write-port and round-robin next state; tag/data hold when idle
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wen0_d   = g0_vld && !flush;
    wen1_d   = g1_vld && !flush;
    out0_d   = out0_q;
    out1_d   = out1_q;
    if (wen0_d) out0_d = head[g0_idx];
    if (wen1_d) out1_d = head[g1_idx];
    if (!flush) begin
      if (g1_vld)      rr_ptr_d = next_idx(g1_idx);
      else if (g0_vld) rr_ptr_d = next_idx(g0_idx);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_ptr_q <= '0;
      wen0_q   <= 1'b0;
      wen1_q   <= 1'b0;
      out0_q   <= '0;
      out1_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      wen0_q   <= wen0_d;
      wen1_q   <= wen1_d;
      out0_q   <= out0_d;
      out1_q   <= out1_d;
    end
  end

  // FIFO storage; flushed pushes are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (push[i] && !flush) begin
          mem_q[i][wr_ptr_q[i]] <= '{tag: fu_tag[i], data: fu_data[i]};
        end
      end
    end
  end

  assign wen0   = wen0_q;
  assign wtag0  = out0_q.tag;
  assign wdata0 = out0_q.data;
  assign wen1   = wen1_q;
  assign wtag1  = out1_q.tag;
  assign wdata1 = out1_q.data;

`ifdef WB_ARB_STATS_EN
  logic [31:0] wb_count_q, stall_q;
  logic [1:0]  ngrant;
  logic        stall_hit;

  // Grants actually written this cycle, and whether any ready result waited
  always_comb begin
    ngrant    = 2'(wen0_d) + 2'(wen1_d);
    stall_hit = |(nonempty & ~pop);
  end

  // Saturating statistics; survive flush, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_count_q <= '0;
      stall_q    <= '0;
    end else begin
      if ((33'(wb_count_q) + 33'(ngrant)) > 33'h0_FFFF_FFFF) wb_count_q <= '1;
      else wb_count_q <= wb_count_q + 32'(ngrant);
      if (stall_hit && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign wb_count     = wb_count_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_wb_arbiter;
  localparam int NUM_FU = 4;
  localparam int DEPTH  = 2;
  localparam int XLEN   = 32;
  localparam int TAG_W  = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [NUM_FU-1:0]             fu_valid = '0;
  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag   = '0;
  logic [NUM_FU-1:0][XLEN-1:0]   fu_data  = '0;
  logic [NUM_FU-1:0]             fu_ready;
  logic                          wen0, wen1;
  logic [TAG_W-1:0]              wtag0, wtag1;
  logic [XLEN-1:0]               wdata0, wdata1;
`ifdef WB_ARB_STATS_EN
  logic [31:0]                   wb_count, stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [TAG_W+XLEN-1:0] mq [NUM_FU][$];
  logic             e_wen0 = 1'b0, e_wen1 = 1'b0;
  logic [TAG_W-1:0] e_tag0 = '0, e_tag1 = '0;
  logic [XLEN-1:0]  e_dat0 = '0, e_dat1 = '0;
  int rr    = 0;
  int n_acc = 0;
  int n_wr  = 0;
  int owner [64];
  int wlog  [$];
  logic [TAG_W-1:0] next_tag = 6'd10;

  always #5 clk = ~clk;

  wb_arbiter #(.NUM_FU(NUM_FU), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .fu_valid (fu_valid),
    .fu_tag   (fu_tag),
    .fu_data  (fu_data),
    .fu_ready (fu_ready),
    .wen0     (wen0),
    .wtag0    (wtag0),
    .wdata0   (wdata0),
    .wen1     (wen1),
    .wtag1    (wtag1),
    .wdata1   (wdata1)
`ifdef WB_ARB_STATS_EN
    ,
    .wb_count     (wb_count),
    .stall_cycles (stall_cycles)
`endif
  );

  // Reference model: per-FU result queues, round-robin pick of up to two heads
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) mq[i].delete();
      rr = 0;
      e_wen0 = 1'b0; e_wen1 = 1'b0;
      e_tag0 = '0; e_tag1 = '0; e_dat0 = '0; e_dat1 = '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_FU; i++) mq[i].delete();
      e_wen0 = 1'b0; e_wen1 = 1'b0;
    end else begin
      int g [2];
      int ng;
      logic [NUM_FU-1:0] acc;
      ng = 0; g[0] = 0; g[1] = 0;
      for (int i = 0; i < NUM_FU; i++) acc[i] = fu_valid[i] && (mq[i].size() < DEPTH);
      for (int k = 0; k < NUM_FU; k++) begin
        int f;
        f = (rr + k) % NUM_FU;
        if (ng < 2 && mq[f].size() > 0) begin
          g[ng] = f;
          ng++;
        end
      end
      e_wen0 = (ng > 0);
      e_wen1 = (ng > 1);
      if (ng > 0) {e_tag0, e_dat0} = mq[g[0]].pop_front();
      if (ng > 1) {e_tag1, e_dat1} = mq[g[1]].pop_front();
      if (ng > 0) rr = (g[ng-1] + 1) % NUM_FU;
      for (int i = 0; i < NUM_FU; i++) begin
        if (acc[i]) begin
          mq[i].push_back({fu_tag[i], fu_data[i]});
          n_acc++;
        end
      end
    end
  end

  // Scoreboard: DUT write ports and ready against the model every cycle
  always @(negedge clk) begin
    logic [NUM_FU-1:0] exp_rdy;
    for (int i = 0; i < NUM_FU; i++) exp_rdy[i] = (mq[i].size() < DEPTH);
    total++;
    if (wen0 !== e_wen0) begin
      bad++; $display("FAIL sb_wen0 t=%0t got=%b want=%b", $time, wen0, e_wen0);
    end
    total++;
    if (wen1 !== e_wen1) begin
      bad++; $display("FAIL sb_wen1 t=%0t got=%b want=%b", $time, wen1, e_wen1);
    end
    if (e_wen0) begin
      total++;
      if ({wtag0, wdata0} !== {e_tag0, e_dat0}) begin
        bad++; $display("FAIL sb_port0 t=%0t got=%0d/%h want=%0d/%h", $time, wtag0, wdata0, e_tag0, e_dat0);
      end
    end
    if (e_wen1) begin
      total++;
      if ({wtag1, wdata1} !== {e_tag1, e_dat1}) begin
        bad++; $display("FAIL sb_port1 t=%0t got=%0d/%h want=%0d/%h", $time, wtag1, wdata1, e_tag1, e_dat1);
      end
    end
    total++;
    if (fu_ready !== exp_rdy) begin
      bad++; $display("FAIL sb_ready t=%0t got=%b want=%b", $time, fu_ready, exp_rdy);
    end
    if (wen0 === 1'b1 && wen1 === 1'b1) begin
      total++;
      if (wtag0 === wtag1) begin
        bad++; $display("FAIL tag_distinct t=%0t tag0=%0d tag1=%0d", $time, wtag0, wtag1);
      end
    end
    if (wen0 === 1'b1) begin n_wr++; wlog.push_back(owner[wtag0]); end
    if (wen1 === 1'b1) begin n_wr++; wlog.push_back(owner[wtag1]); end
  end

  // FU behaviour: hold each result until accepted; optional random flush
  task automatic drive(input int ncyc, input logic [NUM_FU-1:0] mask, input int pct, input int fpct);
    logic [NUM_FU-1:0] rdy;
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (!fu_valid[i] && mask[i] && int'($urandom_range(99)) < pct) begin
          fu_valid[i] = 1'b1;
          fu_tag[i]   = next_tag;
          fu_data[i]  = $urandom;
          owner[next_tag] = i;
          next_tag++;
        end
      end
      flush = (int'($urandom_range(99)) < fpct);
      rdy = fu_ready;
      @(negedge clk);
      for (int i = 0; i < NUM_FU; i++) if (fu_valid[i] && rdy[i]) fu_valid[i] = 1'b0;
    end
    flush = 1'b0;
  endtask

  task automatic drain();
    drive(20, '0, 0, 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({wen0, wen1} !== 2'b00) begin
      bad++; $display("FAIL reset_wen got=%b want=00", {wen0, wen1});
    end
    total++;
    if ({wtag0, wtag1, wdata0, wdata1} !== '0) begin
      bad++; $display("FAIL reset_tagdata got=%0d/%0d/%h/%h want=0", wtag0, wtag1, wdata0, wdata1);
    end
    total++;
    if (fu_ready !== 4'b1111) begin
      bad++; $display("FAIL reset_ready got=%b want=1111", fu_ready);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    fu_valid = 4'b0100; fu_tag[2] = 6'd5; fu_data[2] = 32'hDEAD_BEEF; owner[5] = 2;
    @(negedge clk);
    fu_valid = '0;
    #1;
    total++;
    if (wen0 !== 1'b0) begin
      bad++; $display("FAIL single_early got=%b want=0", wen0);
    end
    @(negedge clk); #1;
    total++;
    if ({wen0, wtag0, wdata0, wen1} !== {1'b1, 6'd5, 32'hDEAD_BEEF, 1'b0}) begin
      bad++; $display("FAIL single_write got=%b/%0d/%h/%b want=1/5/deadbeef/0", wen0, wtag0, wdata0, wen1);
    end
    @(negedge clk); #1;
    total++;
    if (wen0 !== 1'b0) begin
      bad++; $display("FAIL single_after got=%b want=0", wen0);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    fu_valid = 4'b1111;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_tag[i] = 6'(i + 1); fu_data[i] = 32'h1000 + 32'(i); owner[i+1] = i;
    end
    @(negedge clk);
    fu_valid = '0;
    @(negedge clk); #1;
    total++;
    if ({wen0, wen1, wtag0, wtag1} !== {1'b1, 1'b1, 6'd1, 6'd2}) begin
      bad++; $display("FAIL four_pair1 got=%b%b/%0d/%0d want=11/1/2", wen0, wen1, wtag0, wtag1);
    end
    @(negedge clk); #1;
    total++;
    if ({wen0, wen1, wtag0, wtag1} !== {1'b1, 1'b1, 6'd3, 6'd4}) begin
      bad++; $display("FAIL four_pair2 got=%b%b/%0d/%0d want=11/3/4", wen0, wen1, wtag0, wtag1);
    end
    @(negedge clk); #1;
    total++;
    if ({wen0, wen1} !== 2'b00) begin
      bad++; $display("FAIL four_idle got=%b%b want=00", wen0, wen1);
    end
  endtask

  task automatic test_rotation();
    int exp_own [8] = '{0, 1, 2, 0, 1, 2, 0, 1};
    do_reset();
    wlog.delete();
    drive(8, 4'b0111, 100, 0);
    #1;
    total++;
    if (wlog.size() < 8) begin
      bad++; $display("FAIL rot_count got=%0d want>=8", wlog.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        total++;
        if (wlog[j] !== exp_own[j]) begin
          bad++; $display("FAIL rot_order idx=%0d got=%0d want=%0d", j, wlog[j], exp_own[j]);
        end
      end
    end
    drain();
  endtask

  task automatic test_saturate();
    int a0, w0;
    do_reset();
    a0 = n_acc; w0 = n_wr;
    drive(2, 4'b1111, 100, 0);
    #1;
    total++;
    if (fu_ready === 4'b1111) begin
      bad++; $display("FAIL sat_ready_drop got=%b want=not 1111", fu_ready);
    end
    drive(40, 4'b1111, 100, 0);
    drain();
    #1;
    total++;
    if ((n_wr - w0) !== (n_acc - a0) || (n_acc - a0) < 40) begin
      bad++; $display("FAIL sat_conserve got=%0d writes want=%0d accepted", n_wr - w0, n_acc - a0);
    end
  endtask

  task automatic test_flush();
`ifdef WB_ARB_STATS_EN
    logic [31:0] wbc;
`endif
    do_reset();
    drive(6, 4'b1111, 100, 0);
    fu_valid = 4'b1111;
    flush = 1'b1;
`ifdef WB_ARB_STATS_EN
    wbc = wb_count;
`endif
    @(negedge clk);
    flush = 1'b0;
    fu_valid = '0;
    #1;
    total++;
    if ({wen0, wen1, fu_ready} !== {2'b00, 4'b1111}) begin
      bad++; $display("FAIL flush_state got=%b%b/%b want=00/1111", wen0, wen1, fu_ready);
    end
`ifdef WB_ARB_STATS_EN
    total++;
    if (wb_count !== wbc) begin
      bad++; $display("FAIL flush_wbcount got=%0d want=%0d", wb_count, wbc);
    end
`endif
    @(negedge clk); #1;
    total++;
    if ({wen0, wen1} !== 2'b00) begin
      bad++; $display("FAIL flush_after got=%b%b want=00", wen0, wen1);
    end
  endtask

  task automatic test_reset_mid();
    drive(10, 4'b1111, 100, 0);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({wen0, wen1} !== 2'b00) begin
      bad++; $display("FAIL rmid_wen got=%b%b want=00", wen0, wen1);
    end
    fu_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (fu_ready !== 4'b1111) begin
      bad++; $display("FAIL rmid_ready got=%b want=1111", fu_ready);
    end
    @(negedge clk); #1;
    total++;
    if ({wen0, wen1} !== 2'b00) begin
      bad++; $display("FAIL rmid_nowrite got=%b%b want=00", wen0, wen1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(50, 4'($urandom), 20 + int'($urandom_range(70)), 3);
    end
    drain();
    #1;
    total++;
    if (fu_ready !== 4'b1111 || wen0 !== 1'b0) begin
      bad++; $display("FAIL rand_drained got=%b/%b want=1111/0", fu_ready, wen0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_rotation();
    test_saturate();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
